microsequencer: RTL and testbench
=================================

Name: microsequencer

Overview:
- Drives the 16-bit microinstruction word that the control decoder turns into bus, ALU and jump strobes.
- Owns the T-state counter, the program counter and a run/stop/single-step state machine.
- Forms the microcode ROM address from the opcode and the T-state.
- Sits between the instruction register, the microcode ROM and the control decoder; it consumes the decoder's RT, P+ and jump outputs.

Parameters:
- TSTATE_BITS, 3: T-state counter width; maximum of 8 T-states per instruction.
- OPCODE_BITS, 8: opcode width, taken from IR[15:8].
- START_RUNNING, 1: state after reset; 1 = RUNNING, 0 = STOPPED.

Ports:
- clk  in  1  system clock; all state updates on the rising edge.
- reset_bar  in  1  asynchronous active-low reset.
- opcode  in  OPCODE_BITS  instruction register high byte.
- urom_data  in  16  microcode ROM data for address uaddr.
- uaddr  out  OPCODE_BITS+TSTATE_BITS  ROM address = {opcode, tstate}, combinational.
- uinstr  out  16  microinstruction presented to the control decoder.
- rt  in  1  decoder RT: reset the T-state at the end of this cycle.
- pp  in  1  decoder P+: increment the PC.
- jmp  in  1  active-high jump, equal to the inverse of the decoder's JMP_bar.
- bus  in  16  data bus value; loaded into the PC on jmp.
- pc  out  16  program counter; drives the bus when PO_bar is active.
- tstate  out  TSTATE_BITS  current T-state.
- run  in  1  level: 1 = free-run, 0 = stop at the next instruction boundary.
- step  in  1  single-step request, rising-edge sensitive.
- stopped  out  1  high while in STOPPED.

Behaviour:
- Asynchronous reset, effective immediately even mid-instruction:
  - tstate=0, pc=0, step_q=0.
  - state = RUNNING if START_RUNNING, else STOPPED.
- Constants:
  - FETCH0 = 16'h8020 (PC out, address in).
  - FETCH1 = 16'hB440 (memory out, IR in, P+).
  - NOP = 16'h8000 (no bus input, no P+, no RT, no jump bits).
- uinstr, combinational:
  - STOPPED: NOP.
  - Otherwise tstate 0 gives FETCH0, tstate 1 gives FETCH1, and tstate 2 or higher gives urom_data.
  - urom_data is ignored during T0 and T1.
- "Active" means state RUNNING or STEPPING. On each active edge:
  - tstate_next = 0 if rt, or if tstate is at its maximum (wrap); otherwise tstate+1.
  - Boundary = (tstate_next == 0).
- PC, updated only when active:
  - jmp loads bus; jmp has priority over pp.
  - pp alone increments; 16'hFFFF wraps to 0.
  - Neither: hold.
- STOPPED: tstate and pc are held, and rt, pp and jmp are ignored.
- step_q registers step every cycle. step_rise = step & ~step_q.
- State transitions, evaluated at the edge:
  - RUNNING: at a boundary with run=0, go to STOPPED. Otherwise stay.
  - STOPPED: run=1 goes to RUNNING. Else step_rise goes to STEPPING. Else stay.
  - STEPPING: at a boundary, go to RUNNING if run=1, else STOPPED. Otherwise stay.
- Stopping happens only at instruction boundaries; a run drop mid-instruction completes the instruction first.
- Latency: from stop, the first FETCH0 appears on uinstr the cycle after run rises or step rises.
- Simultaneous run and step rising while STOPPED: run wins and the state goes to RUNNING.
- A step held high produces exactly one instruction.
- rt asserted at T0 or T1 is illegal microcode. The sequencer still honours it as a T-state reset.

Decomposition:
- Package microseq_pkg:
  - uinstr field bit positions (EO_bar, bus_out, bus_in, RT, P+, JZ/JGT/JLT).
  - FETCH0, FETCH1 and NOP constants.
  - State enum {RUNNING, STOPPED, STEPPING}.
- One natural sub-module: program_counter, a 16-bit register with load, increment, enable and asynchronous reset.
- The T-state counter and state machine stay in microsequencer.

Test Plan:
- Reset then free run: with START_RUNNING=1, pc=0 and tstate=0. uinstr must read 8020, then B440, then urom_data at T2. After the T1 edge pc=1. uaddr at T2 = {opcode, 3'd2}.
- RT at T3: tstate sequence must be 0,1,2,3,0, with FETCH0 on the fifth cycle. With no RT the sequence must run to 7 and then wrap to 0.
- Jump with P+ together: jmp=1, pp=1, bus=16'h1234 → pc=16'h1234 next cycle. pc=16'hFFFF with pp alone → pc=0.
- Stop: drop run at T2 of an instruction that ends with RT at T4. Required: completes T3 and T4, then stopped=1, uinstr=8000 and pc frozen over 10 cycles of rt, pp and jmp held high.
- Single step: from STOPPED, hold step high for 20 cycles. Exactly one instruction executes (FETCH0 ... boundary), then stopped=1 again. A second rising edge executes one more.
- Reset mid-instruction: assert reset_bar low asynchronously at T5 with pc=16'h0040. Required: tstate=0 and pc=0 immediately, without waiting for a clock edge.

Source files
------------

// File: rtl/microsequencer_pkg.sv
`default_nettype none
// ============================================================================
// Module      : microseq_pkg
// Description : Shared microinstruction field map, fixed fetch words and the
//               sequencer state encoding.
// Revision    : 1.0  initial release
// ============================================================================
package microseq_pkg;

    // Microinstruction word field positions
    localparam int UI_EO_BAR      = 15;
    localparam int UI_BUS_OUT_MSB = 14;
    localparam int UI_BUS_OUT_LSB = 12;
    localparam int UI_BUS_IN_MSB  = 11;
    localparam int UI_BUS_IN_LSB  = 8;
    localparam int UI_RT          = 7;
    localparam int UI_PP          = 6;
    localparam int UI_MI          = 5;
    localparam int UI_JZ          = 2;
    localparam int UI_JGT         = 1;
    localparam int UI_JLT         = 0;

    // Fixed words for the two fetch T-states and the idle word
    localparam logic [15:0] C_FETCH0 = 16'h8020;
    localparam logic [15:0] C_FETCH1 = 16'hB440;
    localparam logic [15:0] C_NOP    = 16'h8000;

    typedef enum logic [1:0] {
        ST_RUNNING  = 2'd0,
        ST_STOPPED  = 2'd1,
        ST_STEPPING = 2'd2
    } seq_state_t;

endpackage : microseq_pkg
`default_nettype wire

// File: rtl/microsequencer_program_counter.sv
`default_nettype none
// ============================================================================
// Module      : program_counter
// Description : 16-bit program counter with enable, load (priority) and
//               increment, asynchronously cleared.
// Revision    : 1.0  initial release
// ============================================================================
module program_counter #(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             reset_bar,
    input  logic             en,
    input  logic             load,
    input  logic             inc,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);

    logic [WIDTH-1:0] r_pc;
    logic [WIDTH-1:0] w_pc_next;

    // Load beats increment; increment wraps naturally at all-ones
    always_comb begin
        w_pc_next = r_pc;
        if (en) begin
            if (load) begin
                w_pc_next = d;
            end else if (inc) begin
                w_pc_next = r_pc + WIDTH'(1);
            end
        end
    end

    always_ff @(posedge clk or negedge reset_bar) begin
        if (!reset_bar) begin
            r_pc <= '0;
        end else begin
            r_pc <= w_pc_next;
        end
    end

    assign q = r_pc;

endmodule : program_counter
`default_nettype wire

// File: rtl/microsequencer.sv
`default_nettype none
// ============================================================================
// Module      : microsequencer
// Description : T-state counter, program counter and run/stop/single-step
//               control that forms the microcode ROM address and microword.
// Revision    : 1.0  initial release
// ============================================================================
module microsequencer
    import microseq_pkg::*;
#(
    parameter int TSTATE_BITS   = 3,
    parameter int OPCODE_BITS   = 8,
    parameter bit START_RUNNING = 1'b1
) (
    input  logic                               clk,
    input  logic                               reset_bar,
    input  logic [OPCODE_BITS-1:0]             opcode,
    input  logic [15:0]                        urom_data,
    output logic [OPCODE_BITS+TSTATE_BITS-1:0] uaddr,
    output logic [15:0]                        uinstr,
    input  logic                               rt,
    input  logic                               pp,
    input  logic                               jmp,
    input  logic [15:0]                        bus,
    output logic [15:0]                        pc,
    output logic [TSTATE_BITS-1:0]             tstate,
    input  logic                               run,
    input  logic                               step,
    output logic                               stopped
);

    localparam logic [TSTATE_BITS-1:0] C_TSTATE_MAX = '1;
    localparam seq_state_t C_RESET_STATE = START_RUNNING ? ST_RUNNING : ST_STOPPED;

    seq_state_t             r_state;
    seq_state_t             w_state_next;
    logic [TSTATE_BITS-1:0] r_tstate;
    logic [TSTATE_BITS-1:0] w_tstate_next;
    logic                   r_step_q;
    logic                   w_step_rise;
    logic                   w_active;
    logic                   w_boundary;

    assign w_active    = (r_state != ST_STOPPED);
    assign w_step_rise = step & ~r_step_q;

    // rt is honoured at any T-state, including the fetch states
    assign w_tstate_next = (rt || (r_tstate == C_TSTATE_MAX)) ? '0
                                                              : r_tstate + TSTATE_BITS'(1);
    assign w_boundary    = (w_tstate_next == '0);

    always_ff @(posedge clk or negedge reset_bar) begin
        if (!reset_bar) begin
            r_tstate <= '0;
            r_step_q <= 1'b0;
        end else begin
            r_step_q <= step;
            if (w_active) begin
                r_tstate <= w_tstate_next;
            end
        end
    end

    program_counter #(
        .WIDTH (16)
    ) u_program_counter (
        .clk       (clk),
        .reset_bar (reset_bar),
        .en        (w_active),
        .load      (jmp),
        .inc       (pp),
        .d         (bus),
        .q         (pc)
    );

    // FSM: state register
    always_ff @(posedge clk or negedge reset_bar) begin
        if (!reset_bar) begin
            r_state <= C_RESET_STATE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // FSM: next state; leaving an active state only happens at a boundary
    always_comb begin
        w_state_next = r_state;
        case (r_state)
            ST_RUNNING: begin
                if (w_boundary && !run) begin
                    w_state_next = ST_STOPPED;
                end
            end
            ST_STOPPED: begin
                if (run) begin
                    w_state_next = ST_RUNNING;
                end else if (w_step_rise) begin
                    w_state_next = ST_STEPPING;
                end
            end
            ST_STEPPING: begin
                if (w_boundary) begin
                    w_state_next = run ? ST_RUNNING : ST_STOPPED;
                end
            end
            default: begin
                w_state_next = ST_STOPPED;
            end
        endcase
    end

    // FSM: outputs
    always_comb begin
        uinstr  = C_NOP;
        stopped = 1'b0;
        if (r_state == ST_STOPPED) begin
            stopped = 1'b1;
        end else if (r_tstate == '0) begin
            uinstr = C_FETCH0;
        end else if (r_tstate == TSTATE_BITS'(1)) begin
            uinstr = C_FETCH1;
        end else begin
            uinstr = urom_data;
        end
    end

    assign uaddr  = {opcode, r_tstate};
    assign tstate = r_tstate;

endmodule : microsequencer
`default_nettype wire

// File: tb/tb_microsequencer.sv
`default_nettype none
// ============================================================================
// Module      : tb_microsequencer
// Description : Directed vector table plus hand-written stop, step and reset
//               sequences for the microsequencer.
// Revision    : 1.0  initial release
// ============================================================================
module tb_microsequencer;

    logic        clk;
    logic        reset_bar;
    logic [7:0]  opcode;
    logic [15:0] urom_data;
    logic [10:0] uaddr;
    logic [15:0] uinstr;
    logic        rt;
    logic        pp;
    logic        jmp;
    logic [15:0] bus;
    logic [15:0] pc;
    logic [2:0]  tstate;
    logic        run;
    logic        step;
    logic        stopped;

    int n_vec;
    int n_bad;

    microsequencer #(
        .TSTATE_BITS   (3),
        .OPCODE_BITS   (8),
        .START_RUNNING (1'b1)
    ) dut (
        .clk       (clk),
        .reset_bar (reset_bar),
        .opcode    (opcode),
        .urom_data (urom_data),
        .uaddr     (uaddr),
        .uinstr    (uinstr),
        .rt        (rt),
        .pp        (pp),
        .jmp       (jmp),
        .bus       (bus),
        .pc        (pc),
        .tstate    (tstate),
        .run       (run),
        .step      (step),
        .stopped   (stopped)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        pp;
        logic        jmp;
        logic        rt;
        logic [15:0] bus;
        logic [15:0] urom;
        logic [2:0]  exp_t;
        logic [15:0] exp_pc;
        logic [15:0] exp_ui;
        logic [10:0] exp_ua;
    } vec_t;

    vec_t vecs[18];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout, expected $finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int active_cnt;
        logic [15:0] first_ui;
        logic seen;

        n_vec = 0;
        n_bad = 0;
        reset_bar = 1'b0;
        opcode = 8'hA5;
        urom_data = 16'h0;
        rt = 0; pp = 0; jmp = 0; bus = 16'h0;
        run = 1'b1;
        step = 1'b0;

        //         pp jmp rt  bus       urom      t     pc        uinstr    uaddr
        vecs[0]  = '{0, 0, 0, 16'h0000, 16'h1111, 3'd0, 16'h0000, 16'h8020, 11'h528};
        vecs[1]  = '{1, 0, 0, 16'h0000, 16'h1111, 3'd1, 16'h0000, 16'hB440, 11'h529};
        vecs[2]  = '{0, 0, 0, 16'h0000, 16'h1111, 3'd2, 16'h0001, 16'h1111, 11'h52A};
        vecs[3]  = '{0, 0, 0, 16'h0000, 16'h2222, 3'd3, 16'h0001, 16'h2222, 11'h52B};
        vecs[4]  = '{0, 0, 0, 16'h0000, 16'h3333, 3'd4, 16'h0001, 16'h3333, 11'h52C};
        vecs[5]  = '{0, 0, 0, 16'h0000, 16'h5555, 3'd5, 16'h0001, 16'h5555, 11'h52D};
        vecs[6]  = '{0, 0, 0, 16'h0000, 16'h6666, 3'd6, 16'h0001, 16'h6666, 11'h52E};
        vecs[7]  = '{0, 0, 0, 16'h0000, 16'h7777, 3'd7, 16'h0001, 16'h7777, 11'h52F};
        vecs[8]  = '{0, 0, 0, 16'h0000, 16'h9999, 3'd0, 16'h0001, 16'h8020, 11'h528};
        vecs[9]  = '{1, 0, 0, 16'h0000, 16'h9999, 3'd1, 16'h0001, 16'hB440, 11'h529};
        vecs[10] = '{0, 0, 0, 16'h0000, 16'h4444, 3'd2, 16'h0002, 16'h4444, 11'h52A};
        vecs[11] = '{0, 0, 1, 16'h0000, 16'h4545, 3'd3, 16'h0002, 16'h4545, 11'h52B};
        vecs[12] = '{0, 0, 0, 16'h0000, 16'h0000, 3'd0, 16'h0002, 16'h8020, 11'h528};
        vecs[13] = '{1, 1, 0, 16'h1234, 16'h0000, 3'd1, 16'h0002, 16'hB440, 11'h529};
        vecs[14] = '{0, 1, 0, 16'hFFFF, 16'h0000, 3'd2, 16'h1234, 16'h0000, 11'h52A};
        vecs[15] = '{1, 0, 0, 16'h0000, 16'h0000, 3'd3, 16'hFFFF, 16'h0000, 11'h52B};
        vecs[16] = '{0, 0, 1, 16'h0000, 16'h0000, 3'd4, 16'h0000, 16'h0000, 11'h52C};
        vecs[17] = '{0, 0, 0, 16'h0000, 16'h0000, 3'd0, 16'h0000, 16'h8020, 11'h528};

        // Reset state
        repeat (3) @(posedge clk);
        #2;
        check("reset_tstate", 32'(tstate), 32'd0);
        check("reset_pc", 32'(pc), 32'h0);
        check("reset_stopped", 32'(stopped), 32'd0);
        @(negedge clk);
        reset_bar = 1'b1;

        // Free run through the vector table
        for (int i = 0; i < 18; i++) begin
            pp = vecs[i].pp; jmp = vecs[i].jmp; rt = vecs[i].rt;
            bus = vecs[i].bus; urom_data = vecs[i].urom;
            #1;
            check($sformatf("v%0d_tstate", i), 32'(tstate), 32'(vecs[i].exp_t));
            check($sformatf("v%0d_pc", i), 32'(pc), 32'(vecs[i].exp_pc));
            check($sformatf("v%0d_uinstr", i), 32'(uinstr), 32'(vecs[i].exp_ui));
            check($sformatf("v%0d_uaddr", i), 32'(uaddr), 32'(vecs[i].exp_ua));
            check($sformatf("v%0d_stopped", i), 32'(stopped), 32'd0);
            tick();
        end
        pp = 0; jmp = 0; rt = 0; urom_data = 16'h0;

        // Stop: run drops at T2, instruction ends with RT at T4
        pp = 1; tick();            // T1 -> T2, pc 0 -> 1
        pp = 0; run = 0;
        check("stop_t2", 32'(tstate), 32'd2);
        tick();
        check("stop_t3_tstate", 32'(tstate), 32'd3);
        check("stop_t3_running", 32'(stopped), 32'd0);
        tick();
        rt = 1;
        check("stop_t4_tstate", 32'(tstate), 32'd4);
        check("stop_t4_running", 32'(stopped), 32'd0);
        tick();
        check("stop_stopped", 32'(stopped), 32'd1);
        check("stop_uinstr", 32'(uinstr), 32'h8000);
        check("stop_tstate", 32'(tstate), 32'd0);
        pp = 1; jmp = 1; bus = 16'hABCD;
        for (int i = 0; i < 10; i++) begin
            tick();
            check($sformatf("frozen%0d_pc", i), 32'(pc), 32'h1);
            check($sformatf("frozen%0d_tstate", i), 32'(tstate), 32'd0);
            check($sformatf("frozen%0d_stopped", i), 32'(stopped), 32'd1);
        end
        rt = 0; pp = 0; jmp = 0;

        // Single step with step held high: one full 8-state instruction
        step = 1;
        active_cnt = 0; seen = 0; first_ui = 16'h0;
        for (int i = 0; i < 20; i++) begin
            tick();
            if (!stopped) begin
                if (!seen) first_ui = uinstr;
                seen = 1;
                active_cnt++;
            end
        end
        check("step1_cycles", 32'(active_cnt), 32'd8);
        check("step1_first_uinstr", 32'(first_ui), 32'h8020);
        check("step1_stopped", 32'(stopped), 32'd1);
        check("step1_pc", 32'(pc), 32'h1);

        step = 0; tick();
        step = 1;
        active_cnt = 0;
        for (int i = 0; i < 12; i++) begin
            tick();
            if (!stopped) active_cnt++;
        end
        check("step2_cycles", 32'(active_cnt), 32'd8);
        check("step2_stopped", 32'(stopped), 32'd1);

        // Run and step rising together: run wins
        step = 0; tick();
        run = 1; step = 1;
        tick();
        check("runstep_stopped", 32'(stopped), 32'd0);
        check("runstep_uinstr", 32'(uinstr), 32'h8020);
        check("runstep_tstate", 32'(tstate), 32'd0);
        repeat (8) tick();
        check("runstep_wrap_tstate", 32'(tstate), 32'd0);
        check("runstep_still_running", 32'(stopped), 32'd0);
        step = 0;

        // Asynchronous reset mid-instruction at T5 with pc = 0040
        jmp = 1; bus = 16'h0040;
        tick();
        jmp = 0;
        repeat (4) tick();
        check("pre_reset_tstate", 32'(tstate), 32'd5);
        check("pre_reset_pc", 32'(pc), 32'h0040);
        #2;
        reset_bar = 1'b0;
        #1;
        check("async_reset_tstate", 32'(tstate), 32'd0);
        check("async_reset_pc", 32'(pc), 32'h0);
        check("async_reset_stopped", 32'(stopped), 32'd0);
        @(negedge clk);
        reset_bar = 1'b1;
        tick();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule : tb_microsequencer
`default_nettype wire
